// File: rtl/decode_hs_if.sv
// ID/EX handshake bundle between decode (master) and execute (slave).
// Carries the registered payload plus the out_valid/out_ready pair.
interface decode_hs_if #(
    parameter int XLEN = 32
);
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] imm_o;
    logic [XLEN-1:0] rs1_o;
    logic [XLEN-1:0] rs2_o;
    logic [4:0]      rd_addr_o;
    logic            rd_we_o;
    logic [2:0]      opfunc3_o;
    logic [2:0]      optype_o;
    logic            shiftsel_o;
    logic            addsubsel_o;
    logic            typesel_o;
    logic            mem_re_o;
    logic            mem_we_o;
    logic [4:0]      fwd_raddr1_o;
    logic [4:0]      fwd_raddr2_o;
    logic            illegal_o;

    modport master (
        output out_valid_o, pc_o, imm_o, rs1_o, rs2_o, rd_addr_o, rd_we_o,
               opfunc3_o, optype_o, shiftsel_o, addsubsel_o, typesel_o,
               mem_re_o, mem_we_o, fwd_raddr1_o, fwd_raddr2_o, illegal_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o, pc_o, imm_o, rs1_o, rs2_o, rd_addr_o, rd_we_o,
               opfunc3_o, optype_o, shiftsel_o, addsubsel_o, typesel_o,
               mem_re_o, mem_we_o, fwd_raddr1_o, fwd_raddr2_o, illegal_o,
        output out_ready_i
    );
endinterface

// File: rtl/decode_hs.sv
// RV32I/M instruction decode stage with valid/ready handshakes on both sides,
// load-use interlock over one or two load stages, and illegal-opcode flagging.
module decode_hs #(
    parameter int          XLEN           = 32,
    parameter bit          EN_MEXT        = 1'b1,
    parameter int unsigned LOAD_USE_DEPTH = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] reg_data1_i,
    input  logic [XLEN-1:0] reg_data2_i,
    input  logic            flush_i,
    output logic            hazard_o,
    decode_hs_if.master     id_ex
);

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_RM    = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [6:0] F7_MUL = 7'b0000001;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [2:0] OPT_R   = 3'b000;
    localparam logic [2:0] OPT_I   = 3'b001;
    localparam logic [2:0] OPT_B   = 3'b010;
    localparam logic [2:0] OPT_S   = 3'b011;
    localparam logic [2:0] OPT_U   = 3'b100;
    localparam logic [2:0] OPT_M   = 3'b101;
    localparam logic [2:0] OPT_J   = 3'b110;
    localparam logic [2:0] OPT_LDX = 3'b111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode     = inst_i[6:0];
    assign rd         = inst_i[11:7];
    assign funct3     = inst_i[14:12];
    assign rs1_addr_o = inst_i[19:15];
    assign rs2_addr_o = inst_i[24:20];
    assign funct7     = inst_i[31:25];

    logic is_i, is_rm, is_r, is_m, is_l, is_s, is_lui, is_auipc;
    logic is_jal, is_jalr, is_b, illegal;

    assign is_i     = (opcode == OP_IMM);
    assign is_rm    = (opcode == OP_RM);
    assign is_m     = is_rm && (funct7 == F7_MUL) && EN_MEXT;
    assign is_r     = is_rm && (funct7 != F7_MUL);
    assign is_l     = (opcode == OP_LOAD);
    assign is_s     = (opcode == OP_STORE);
    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_b     = (opcode == OP_BR);
    assign illegal  = !(is_i || is_r || is_m || is_l || is_s || is_lui ||
                        is_auipc || is_jal || is_jalr || is_b);

    logic [XLEN-1:0] imm_d;
    logic [2:0]      optype_d;
    logic [2:0]      opfunc3_d;
    logic            rd_we_d;
    logic            uses_rs1;
    logic            uses_rs2;

    always_comb begin
        imm_d = '0;
        if (is_i || is_l || is_jalr)
            imm_d = {{20{inst_i[31]}}, inst_i[31:20]};
        else if (is_s)
            imm_d = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        else if (is_b)
            imm_d = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                     inst_i[11:8], 1'b0};
        else if (is_lui || is_auipc)
            imm_d = {inst_i[31:12], 12'b0};
        else if (is_jal)
            imm_d = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                     inst_i[30:21], 1'b0};
    end

    // Loads and illegal opcodes share 111; illegal_o tells them apart.
    always_comb begin
        optype_d = OPT_LDX;
        if (is_r)                   optype_d = OPT_R;
        else if (is_i)              optype_d = OPT_I;
        else if (is_b)              optype_d = OPT_B;
        else if (is_s)              optype_d = OPT_S;
        else if (is_lui || is_auipc) optype_d = OPT_U;
        else if (is_m)              optype_d = OPT_M;
        else if (is_jal || is_jalr) optype_d = OPT_J;
    end

    assign opfunc3_d = (is_lui || is_auipc) ? 3'b000 : funct3;
    assign rd_we_d   = (is_i || is_r || is_m || is_l || is_lui || is_auipc ||
                        is_jal || is_jalr) && (rd != 5'd0) && !illegal;
    assign uses_rs1  = is_r || is_m || is_s || is_b || is_i || is_l || is_jalr;
    assign uses_rs2  = is_r || is_m || is_s || is_b;

    logic fire_in, fire_out;
    logic a_hit1, a_hit2, b_hit1, b_hit2;

    // Stage A: a load currently sitting in the ID/EX register.
    assign a_hit1 = id_ex.out_valid_o && id_ex.mem_re_o &&
                    (id_ex.rd_addr_o == rs1_addr_o) && (rs1_addr_o != 5'd0);
    assign a_hit2 = id_ex.out_valid_o && id_ex.mem_re_o &&
                    (id_ex.rd_addr_o == rs2_addr_o) && (rs2_addr_o != 5'd0);

    generate
        if (LOAD_USE_DEPTH == 2) begin : g_shadow
            logic       sh_valid;
            logic [4:0] sh_rd;

            // Stage B remembers a load for one cycle after exe takes it.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sh_valid <= 1'b0;
                    sh_rd    <= 5'd0;
                end else if (flush_i) begin
                    sh_valid <= 1'b0;
                end else if (fire_out && id_ex.mem_re_o) begin
                    sh_valid <= 1'b1;
                    sh_rd    <= id_ex.rd_addr_o;
                end else begin
                    sh_valid <= 1'b0;
                end
            end

            assign b_hit1 = sh_valid && (sh_rd == rs1_addr_o) && (rs1_addr_o != 5'd0);
            assign b_hit2 = sh_valid && (sh_rd == rs2_addr_o) && (rs2_addr_o != 5'd0);
        end else begin : g_no_shadow
            assign b_hit1 = 1'b0;
            assign b_hit2 = 1'b0;
        end
    endgenerate

    assign hazard_o   = in_valid_i && ((uses_rs1 && (a_hit1 || b_hit1)) ||
                                       (uses_rs2 && (a_hit2 || b_hit2)));
    assign in_ready_o = (!id_ex.out_valid_o || id_ex.out_ready_i) && !hazard_o && !flush_i;
    assign fire_in    = in_valid_i && in_ready_o;
    assign fire_out   = id_ex.out_valid_o && id_ex.out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            id_ex.out_valid_o <= 1'b0;
        else if (flush_i)
            id_ex.out_valid_o <= 1'b0;
        else if (fire_in)
            id_ex.out_valid_o <= 1'b1;
        else if (fire_out)
            id_ex.out_valid_o <= 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_ex.pc_o         <= '0;
            id_ex.imm_o        <= '0;
            id_ex.rs1_o        <= '0;
            id_ex.rs2_o        <= '0;
            id_ex.rd_addr_o    <= 5'd0;
            id_ex.rd_we_o      <= 1'b0;
            id_ex.opfunc3_o    <= 3'b000;
            id_ex.optype_o     <= 3'b000;
            id_ex.shiftsel_o   <= 1'b0;
            id_ex.addsubsel_o  <= 1'b0;
            id_ex.typesel_o    <= 1'b0;
            id_ex.mem_re_o     <= 1'b0;
            id_ex.mem_we_o     <= 1'b0;
            id_ex.fwd_raddr1_o <= 5'd0;
            id_ex.fwd_raddr2_o <= 5'd0;
            id_ex.illegal_o    <= 1'b0;
        end else if (fire_in) begin
            id_ex.pc_o         <= pc_i;
            id_ex.imm_o        <= imm_d;
            id_ex.rs1_o        <= reg_data1_i;
            id_ex.rs2_o        <= reg_data2_i;
            id_ex.rd_addr_o    <= rd;
            id_ex.rd_we_o      <= rd_we_d;
            id_ex.opfunc3_o    <= opfunc3_d;
            id_ex.optype_o     <= optype_d;
            id_ex.shiftsel_o   <= (funct7 == F7_ALT);
            id_ex.addsubsel_o  <= is_rm && (funct7 == F7_ALT) && (funct3 == 3'b000);
            id_ex.typesel_o    <= is_jal || is_lui;
            id_ex.mem_re_o     <= is_l;
            id_ex.mem_we_o     <= is_s;
            id_ex.fwd_raddr1_o <= rs1_addr_o;
            id_ex.fwd_raddr2_o <= rs2_addr_o;
            id_ex.illegal_o    <= illegal;
        end
    end

endmodule

// File: tb/tb_decode_hs.sv
// Directed bench for decode_hs: two instances (M on/depth 1, M off/depth 2)
// with a per-instance expected-output queue checked whenever exe consumes.
module tb_decode_hs;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  optype;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        we;
        logic        mre;
        logic        mwe;
        logic        ill;
        logic [4:0]  f1;
        logic [4:0]  f2;
        logic        tsel;
        logic        asel;
        logic        ssel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_a, in_valid_b;
    logic        in_ready_a, in_ready_b;
    logic [31:0] pc, inst, rd1, rd2;
    logic        flush, out_ready;
    logic [4:0]  rs1a_a, rs2a_a, rs1a_b, rs2a_b;
    logic        hazard_a, hazard_b;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b, obs_a, obs_b;

    always #5 clk = ~clk;

    decode_hs_if #(.XLEN(32)) if_a ();
    decode_hs_if #(.XLEN(32)) if_b ();
    assign if_a.out_ready_i = out_ready;
    assign if_b.out_ready_i = out_ready;

    decode_hs #(.XLEN(32), .EN_MEXT(1'b1), .LOAD_USE_DEPTH(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
        .pc_i(pc), .inst_i(inst), .rs1_addr_o(rs1a_a), .rs2_addr_o(rs2a_a),
        .reg_data1_i(rd1), .reg_data2_i(rd2), .flush_i(flush), .hazard_o(hazard_a),
        .id_ex(if_a.master)
    );

    decode_hs #(.XLEN(32), .EN_MEXT(1'b0), .LOAD_USE_DEPTH(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
        .pc_i(pc), .inst_i(inst), .rs1_addr_o(rs1a_b), .rs2_addr_o(rs2a_b),
        .reg_data1_i(rd1), .reg_data2_i(rd2), .flush_i(flush), .hazard_o(hazard_b),
        .id_ex(if_b.master)
    );

    assign obs_a = {if_a.pc_o, if_a.imm_o, if_a.rs1_o, if_a.rs2_o, if_a.optype_o,
                    if_a.opfunc3_o, if_a.rd_addr_o, if_a.rd_we_o, if_a.mem_re_o,
                    if_a.mem_we_o, if_a.illegal_o, if_a.fwd_raddr1_o, if_a.fwd_raddr2_o,
                    if_a.typesel_o, if_a.addsubsel_o, if_a.shiftsel_o};
    assign obs_b = {if_b.pc_o, if_b.imm_o, if_b.rs1_o, if_b.rs2_o, if_b.optype_o,
                    if_b.opfunc3_o, if_b.rd_addr_o, if_b.rd_we_o, if_b.mem_re_o,
                    if_b.mem_we_o, if_b.illegal_o, if_b.fwd_raddr1_o, if_b.fwd_raddr2_o,
                    if_b.typesel_o, if_b.addsubsel_o, if_b.shiftsel_o};

    always @(negedge clk) begin
        if (rst_n && !flush && if_a.out_valid_o && out_ready) begin
            checks++;
            assert (q_a.size() != 0) else begin
                errors++;
                $error("FAIL sb_a_empty: observed output pc=%h expected none", if_a.pc_o);
            end
            if (q_a.size() != 0) begin
                e_a = q_a.pop_front();
                checks++;
                assert (obs_a === e_a) else begin
                    errors++;
                    $error("FAIL sb_a pc=%h: observed %h expected %h", e_a.pc, obs_a, e_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !flush && if_b.out_valid_o && out_ready) begin
            checks++;
            assert (q_b.size() != 0) else begin
                errors++;
                $error("FAIL sb_b_empty: observed output pc=%h expected none", if_b.pc_o);
            end
            if (q_b.size() != 0) begin
                e_b = q_b.pop_front();
                checks++;
                assert (obs_b === e_b) else begin
                    errors++;
                    $error("FAIL sb_b pc=%h: observed %h expected %h", e_b.pc, obs_b, e_b);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] imm, input logic [2:0] optype,
                                input logic [2:0] f3, input logic [4:0] rd,
                                input logic we, input logic mre, input logic mwe,
                                input logic ill, input logic [4:0] f1,
                                input logic [4:0] f2, input logic tsel,
                                input logic asel, input logic ssel);
        exp_t e;
        e = '0;
        e.imm = imm; e.optype = optype; e.f3 = f3; e.rd = rd; e.we = we;
        e.mre = mre; e.mwe = mwe; e.ill = ill; e.f1 = f1; e.f2 = f2;
        e.tsel = tsel; e.asel = asel; e.ssel = ssel;
        return e;
    endfunction

    // Operand data is derived from the pc so each transfer carries unique values.
    task automatic drive(input bit sel_b, input logic [31:0] ins, input logic [31:0] p,
                         input exp_t e, input bit track);
        exp_t t;
        t     = e;
        t.pc  = p;
        t.op1 = p + 32'h1000;
        t.op2 = ~p;
        inst  = ins;
        pc    = p;
        rd1   = p + 32'h1000;
        rd2   = ~p;
        in_valid_a = !sel_b;
        in_valid_b = sel_b;
        if (track) begin
            if (sel_b) q_b.push_back(t);
            else       q_a.push_back(t);
        end
    endtask

    task automatic wait_accept(input bit sel_b, input bit must_now, input string tag);
        bit done;
        logic rdy;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            rdy = sel_b ? in_ready_b : in_ready_a;
            if (must_now && n == 0) chk({tag, "_ready"}, 32'(rdy), 32'd1);
            if (rdy === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s_timeout: observed no accept expected accept", tag);
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    localparam logic [31:0] I_ADDI5  = 32'h00500093;
    localparam logic [31:0] I_ADD2   = 32'h00108133;
    localparam logic [31:0] I_LW5    = 32'h00012283;
    localparam logic [31:0] I_ADD6   = 32'h00028333;
    localparam logic [31:0] I_LW0    = 32'h00012003;
    localparam logic [31:0] I_ADD600 = 32'h00000333;
    localparam logic [31:0] I_ADD7   = 32'h001083B3;
    localparam logic [31:0] I_SUB    = 32'h40208233;
    localparam logic [31:0] I_ADDI8  = 32'h00700413;
    localparam logic [31:0] I_MUL    = 32'h022081B3;
    localparam logic [31:0] I_BAD    = 32'hFFFFFFFF;
    localparam logic [31:0] I_SW     = 32'h00512423;
    localparam logic [31:0] I_LUI    = 32'h123454B7;
    localparam logic [31:0] I_BEQ    = 32'hFE208EE3;
    localparam logic [31:0] I_JAL    = 32'hFF9FF0EF;

    initial begin
        rst_n = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        pc = '0; rd1 = '0; rd2 = '0; flush = 1'b0; out_ready = 1'b1;
        inst = I_ADD6;
        #12;
        chk("rst_valid_a", 32'(if_a.out_valid_o), 32'd0);
        chk("rst_valid_b", 32'(if_b.out_valid_o), 32'd0);
        chk("rst_pc_a", if_a.pc_o, 32'd0);
        chk("rst_imm_a", if_a.imm_o, 32'd0);
        chk("rst_optype_a", 32'(if_a.optype_o), 32'd0);
        chk("rst_rdwe_a", 32'(if_a.rd_we_o), 32'd0);
        chk("rs1_addr_comb", 32'(rs1a_a), 32'd5);
        chk("rs2_addr_comb", 32'(rs2a_a), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back stream, one accept per cycle
        drive(0, I_ADDI5, 32'h100, mk(32'd5, 3'b001, 3'd0, 5'd1, 1, 0, 0, 0, 5'd0, 5'd5, 0, 0, 0), 1);
        wait_accept(0, 1, "tp_addi");
        drive(0, I_ADD2, 32'h104, mk(32'd0, 3'b000, 3'd0, 5'd2, 1, 0, 0, 0, 5'd1, 5'd1, 0, 0, 0), 1);
        wait_accept(0, 1, "tp_add");

        // Load-use, single tracked stage: one bubble
        drive(0, I_LW5, 32'h108, mk(32'd0, 3'b111, 3'd2, 5'd5, 1, 1, 0, 0, 5'd2, 5'd0, 0, 0, 0), 1);
        wait_accept(0, 1, "lu1_lw");
        drive(0, I_ADD6, 32'h10C, mk(32'd0, 3'b000, 3'd0, 5'd6, 1, 0, 0, 0, 5'd5, 5'd0, 0, 0, 0), 1);
        @(negedge clk);
        chk("lu1_hazard", 32'(hazard_a), 32'd1);
        chk("lu1_ready", 32'(in_ready_a), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lu1_bubble", 32'(if_a.out_valid_o), 32'd0);
        chk("lu1_hazard_gone", 32'(hazard_a), 32'd0);
        chk("lu1_accept", 32'(in_ready_a), 32'd1);
        @(posedge clk); #1;
        in_valid_a = 1'b0;

        // Load to x0 never interlocks
        drive(0, I_LW0, 32'h110, mk(32'd0, 3'b111, 3'd2, 5'd0, 0, 1, 0, 0, 5'd2, 5'd0, 0, 0, 0), 1);
        wait_accept(0, 1, "lu_x0_lw");
        drive(0, I_ADD600, 32'h114, mk(32'd0, 3'b000, 3'd0, 5'd6, 1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0), 1);
        wait_accept(0, 1, "lu_x0_add");

        // Load-use with shadow stage: two bubbles
        drive(1, I_LW5, 32'h200, mk(32'd0, 3'b111, 3'd2, 5'd5, 1, 1, 0, 0, 5'd2, 5'd0, 0, 0, 0), 1);
        wait_accept(1, 1, "lu2_lw");
        drive(1, I_ADD6, 32'h204, mk(32'd0, 3'b000, 3'd0, 5'd6, 1, 0, 0, 0, 5'd5, 5'd0, 0, 0, 0), 1);
        @(negedge clk);
        chk("lu2_hazard0", 32'(hazard_b), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lu2_bubble1", 32'(if_b.out_valid_o), 32'd0);
        chk("lu2_hazard1", 32'(hazard_b), 32'd1);
        chk("lu2_ready1", 32'(in_ready_b), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lu2_bubble2", 32'(if_b.out_valid_o), 32'd0);
        chk("lu2_ready2", 32'(in_ready_b), 32'd1);
        @(posedge clk); #1;
        in_valid_b = 1'b0;

        drive(1, I_LW5, 32'h208, mk(32'd0, 3'b111, 3'd2, 5'd5, 1, 1, 0, 0, 5'd2, 5'd0, 0, 0, 0), 1);
        wait_accept(1, 1, "lu2_lw_b");
        drive(1, I_ADD7, 32'h20C, mk(32'd0, 3'b000, 3'd0, 5'd7, 1, 0, 0, 0, 5'd1, 5'd1, 0, 0, 0), 1);
        wait_accept(1, 1, "lu2_indep");
        @(negedge clk);
        chk("lu2_indep_nobubble", 32'(if_b.out_valid_o), 32'd1);
        @(posedge clk); #1;

        // M extension enabled vs disabled, illegal opcode, remaining formats
        drive(0, I_MUL, 32'h300, mk(32'd0, 3'b101, 3'd0, 5'd3, 1, 0, 0, 0, 5'd1, 5'd2, 0, 0, 0), 1);
        wait_accept(0, 1, "mul_a");
        drive(1, I_MUL, 32'h300, mk(32'd0, 3'b111, 3'd0, 5'd3, 0, 0, 0, 1, 5'd1, 5'd2, 0, 0, 0), 1);
        wait_accept(1, 1, "mul_b");
        drive(0, I_BAD, 32'h304, mk(32'd0, 3'b111, 3'd7, 5'd31, 0, 0, 0, 1, 5'd31, 5'd31, 0, 0, 0), 1);
        wait_accept(0, 1, "bad_a");
        drive(0, I_SW, 32'h308, mk(32'd8, 3'b011, 3'd2, 5'd8, 0, 0, 1, 0, 5'd2, 5'd5, 0, 0, 0), 1);
        wait_accept(0, 1, "sw_a");
        drive(0, I_LUI, 32'h30C, mk(32'h12345000, 3'b100, 3'd0, 5'd9, 1, 0, 0, 0, 5'd8, 5'd3, 1, 0, 0), 1);
        wait_accept(0, 1, "lui_a");
        drive(0, I_BEQ, 32'h310, mk(32'hFFFFFFFC, 3'b010, 3'd0, 5'd29, 0, 0, 0, 0, 5'd1, 5'd2, 0, 0, 0), 1);
        wait_accept(0, 1, "beq_a");
        drive(0, I_JAL, 32'h314, mk(32'hFFFFFFF8, 3'b110, 3'd7, 5'd1, 1, 0, 0, 0, 5'd31, 5'd25, 1, 0, 0), 1);
        wait_accept(0, 1, "jal_a");

        // Backpressure holds the output register stable
        drive(0, I_SUB, 32'h400, mk(32'd0, 3'b000, 3'd0, 5'd4, 1, 0, 0, 0, 5'd1, 5'd2, 0, 1, 1), 1);
        wait_accept(0, 1, "bp_sub");
        out_ready = 1'b0;
        drive(0, I_ADDI8, 32'h404, mk(32'd7, 3'b001, 3'd0, 5'd8, 1, 0, 0, 0, 5'd0, 5'd7, 0, 0, 0), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_ready", 32'(in_ready_a), 32'd0);
            chk("bp_valid", 32'(if_a.out_valid_o), 32'd1);
            chk("bp_pc", if_a.pc_o, 32'h400);
            chk("bp_rd", 32'(if_a.rd_addr_o), 32'd4);
            chk("bp_addsub", 32'(if_a.addsubsel_o), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept(0, 1, "bp_release");

        // Flush kills a load in ID/EX and its shadow entry
        drive(1, I_LW5, 32'h500, mk(32'd0, 3'b111, 3'd2, 5'd5, 1, 1, 0, 0, 5'd2, 5'd0, 0, 0, 0), 0);
        wait_accept(1, 1, "fl_lw");
        flush = 1'b1;
        @(negedge clk);
        chk("fl_ready", 32'(in_ready_b), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        drive(1, I_ADD6, 32'h504, mk(32'd0, 3'b000, 3'd0, 5'd6, 1, 0, 0, 0, 5'd5, 5'd0, 0, 0, 0), 1);
        @(negedge clk);
        chk("fl_valid", 32'(if_b.out_valid_o), 32'd0);
        chk("fl_hazard", 32'(hazard_b), 32'd0);
        chk("fl_accept", 32'(in_ready_b), 32'd1);
        @(posedge clk); #1;
        in_valid_b = 1'b0;

        // Asynchronous reset mid-cycle, then accept on the first edge after it
        drive(0, I_ADDI8, 32'h600, mk(32'd7, 3'b001, 3'd0, 5'd8, 1, 0, 0, 0, 5'd0, 5'd7, 0, 0, 0), 1);
        wait_accept(0, 1, "ar_addi");
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(if_a.out_valid_o), 32'd0);
        chk("ar_pc", if_a.pc_o, 32'd0);
        chk("ar_imm", if_a.imm_o, 32'd0);
        chk("ar_rd", 32'(if_a.rd_addr_o), 32'd0);
        chk("ar_rdwe", 32'(if_a.rd_we_o), 32'd0);
        q_a.delete();
        out_ready = 1'b1;
        #2;
        rst_n = 1'b1;
        drive(0, I_LUI, 32'h700, mk(32'h12345000, 3'b100, 3'd0, 5'd9, 1, 0, 0, 0, 5'd8, 5'd3, 1, 0, 0), 1);
        #1;
        chk("ar_first_ready", 32'(in_ready_a), 32'd1);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        @(negedge clk);
        chk("ar_first_valid", 32'(if_a.out_valid_o), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_a_drained", q_a.size(), 32'd0);
        chk("sb_b_drained", q_b.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
